// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_adder_slice.sv
// One-bit full-adder slice; the whole serial datapath reuses this single instance.
module bit_adder_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice walked LSB-first over WIDTH cycles,
// with a start/busy/done handshake and registered sum, carry-out and signed overflow.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; outputs hold the last result
//   ST_RUN  | one operand bit per cycle through the slice; busy high
//   ST_DONE | one-cycle done pulse; start here begins the next operation
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int               CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_carry_msb;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_co;

  bit_adder_slice u_slice (
    .a  (r_op_a[0]),
    .b  (r_op_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_carry_msb <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so cin is deliberately ignored in sub mode.
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_MSB_IN) begin
            r_carry_msb <= w_co;
          end
          if (r_cnt == CNT_LAST) begin
            r_cout  <= w_co;
            r_ovf   <= r_carry_msb ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vector table, handshake and
// reset-abort sequences, and randomized operations against a plain-arithmetic reference.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_tests;
  int n_fail;
  int n_done;
  int n_acc;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
  end

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic; overflow from operand/result sign rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub, input logic mcin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ci;
    logic         ovf;
    bb   = msub ? ~mb : mb;
    ci   = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
    ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  // Caller is between edges; returns one tick after done is seen (DUT in DONE).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsub,
                        input logic tcin, input bit hold_start,
                        output logic [W-1:0] rs, output logic rc, output logic ro);
    int lat;
    bit busy_ok;
    a = ta; b = tb_; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done within 14 cycles at %0t", $time);
    end else begin
      chk("latency", lat, W);
      chk("busy_during_run", {31'd0, busy_ok}, 32'd1);
      chk("busy_low_in_done", {31'd0, busy}, 32'd0);
    end
    n_acc++;
    rs = sum; rc = cout; ro = overflow;
  endtask

  task automatic idle_after();
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic         rsub, rcin;

    n_tests = 0; n_fail = 0; n_done = 0; n_acc = 0;
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};

    #15;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    $monitor("%0t busy=%b done=%b sum=%h cout=%b ovf=%b", $time, busy, done, sum, cout, overflow);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vcin, 1'b0, rs, rc, ro);
      chk("vec_sum", {24'd0, rs}, {24'd0, vecs[i].esum});
      chk("vec_cout", {31'd0, rc}, {31'd0, vecs[i].ecout});
      chk("vec_ovf", {31'd0, ro}, {31'd0, vecs[i].eovf});
      idle_after();
    end

    // start held through RUN must not restart the operation
    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b1, rs, rc, ro);
    chk("hold_start_sum", {24'd0, rs}, 32'h7F);
    idle_after();
    @(posedge clk); #1;
    chk("hold_start_no_restart", {31'd0, busy}, 32'd0);

    // back-to-back: start accepted in DONE
    run_op(8'h10, 8'h05, 1'b0, 1'b0, 1'b0, rs, rc, ro);
    chk("b2b_first_sum", {24'd0, rs}, 32'h15);
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, rs, rc, ro);
    chk("b2b_second_sum", {24'd0, rs}, 32'h03);
    idle_after();

    // asynchronous reset mid-RUN: partial sum of ones must vanish at once
    a = 8'hFF; b = 8'h00; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", n_done, n_acc);
    run_op(8'h02, 8'h03, 1'b0, 1'b0, 1'b0, rs, rc, ro);
    chk("after_abort_sum", {24'd0, rs}, 32'h05);
    idle_after();

    // result holds while inputs wander without start
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, rs, rc, ro);
    idle_after();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_sum", {24'd0, sum}, 32'h7F);
      chk("hold_cout", {31'd0, cout}, 32'd1);
      chk("hold_ovf", {31'd0, overflow}, 32'd1);
      chk("hold_busy", {31'd0, busy}, 32'd0);
      chk("hold_done", {31'd0, done}, 32'd0);
    end

    $monitoroff;

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rsub = 1'($urandom); rcin = 1'($urandom);
      m = model(ra, rb, rsub, rcin);
      run_op(ra, rb, rsub, rcin, 1'b0, rs, rc, ro);
      chk("rand_sum", {24'd0, rs}, {24'd0, m[W-1:0]});
      chk("rand_cout", {31'd0, rc}, {31'd0, m[W]});
      chk("rand_ovf", {31'd0, ro}, {31'd0, m[W+1]});
      if ($urandom_range(1, 0) == 1) idle_after();
    end
    idle_after();

    chk("done_pulse_count", n_done, n_acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller. It sequences one 1-bit full-adder slice over WIDTH clock cycles to add or subtract two WIDTH-bit operands, LSB first. It uses a start/busy/done handshake and reports the result, carry-out and signed overflow. It sits between a requester (test bench or CPU-side control) and the 1-bit adder datapath, trading area for WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
sub  input  1  0 = a+b+cin, 1 = a-b (b inverted, carry-in forced 1, cin ignored).
cin  input  1  carry-in for add mode.
a  input  WIDTH  operand A, latched on accepted start.
b  input  WIDTH  operand B, latched on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse in DONE.
sum  output  WIDTH  result register.
cout  output  1  final carry-out; in sub mode, 1 = no borrow.
overflow  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. While reset is high: state=IDLE, counter=0, carry=0, busy=0, done=0, sum=0, cout=0, overflow=0.
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE:
  - start=1 at an edge: latch opA=a, opB = sub ? ~b : b, carry = sub ? 1 : cin, counter=0, clear sum shift register, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Slice inputs: opA[0], opB[0], carry.
  - At the edge: shift the slice sum bit into sum[WIDTH-1] (sum >> 1), shift opA/opB right by 1, carry = slice carry-out, counter+1.
  - When counter==WIDTH-2 at an edge, also record carry_into_msb = slice carry-out.
  - When counter==WIDTH-1 at an edge: cout = slice carry-out, overflow = carry_into_msb XOR slice carry-out, go to DONE.
  - busy=1 throughout RUN.
- DONE: done=1 for exactly one cycle.
  - start=1 at an edge: accept a new operation as in IDLE (back-to-back allowed); done still deasserts the next cycle.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; done is high between edges E(WIDTH) and E(WIDTH+1). Throughput is one result per WIDTH+1 cycles.
- sum, cout and overflow hold their values from DONE until the next accepted start. On an accepted start, cout and overflow clear to 0. sum is undefined-in-progress (partial shift) during RUN; consumers read it only when done=1 or later.
- start during RUN is ignored and operand inputs are not resampled.
- a, b, sub and cin may change freely after the start edge.
- Reset asserted mid-RUN aborts immediately: all outputs return to reset values and no done pulse is produced.
- All arithmetic is modulo 2^WIDTH; cout carries the bit-WIDTH result.

Decomposition:
- Shared package (adder_pkg):
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module bit_adder_slice (combinational: a, b, ci -> s, co):
  - Instantiated once.
  - Keeps the datapath separable from the FSM and reusable by the existing 1-bit adder work.
- FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
All scenarios use WIDTH=8 and a 20 ns clock period (always #10 clk=~clk), with $monitor on the outputs.
1. Add, no carry: a=8'h35, b=8'h4A, cin=0, sub=0, start pulse -> busy for 8 cycles, done 8 cycles after the start edge, sum=8'h7F, cout=0, overflow=0.
2. Signed overflow: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1. Also a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, overflow=0. Also a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
3. Subtract: sub=1, a=8'h10, b=8'h20, cin=1 (ignored) -> sum=8'hF0, cout=0, overflow=0. Also a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, overflow=1.
4. Handshake:
   - start held high during RUN -> no restart; result of the first operation unchanged.
   - start asserted in DONE with a=8'h01, b=8'h02 -> busy re-rises next cycle; sum=8'h03 8 cycles later.
   - Exactly one done pulse per accepted start.
5. Reset mid-operation: assert reset asynchronously (between edges) at cycle 4 of RUN -> busy, done, sum, cout and overflow drop to 0 immediately; no done pulse. After release, a new start 8'h02+8'h03 gives sum=8'h05.
6. Hold: after done, change a and b with no start -> sum, cout and overflow unchanged for 10 cycles; busy=0, done=0.
